// File: rtl/vga_scanner.sv
// vga_scanner: VGA raster timing generator and pin output stage.
// Produces the framebuffer pixel index for the palette stage and re-aligns the
// returned colour with delayed active/sync before driving the pins.
// Optional feature: define VGA_SCANNER_TEST_PATTERN_EN to add test_pattern_i,
// which replaces the colour source with eight vertical colour bars.
module vga_scanner #(
  parameter int H_ACTIVE          = 640,
  parameter int H_FP              = 16,
  parameter int H_SYNC            = 96,
  parameter int H_BP              = 48,
  parameter int V_ACTIVE          = 480,
  parameter int V_FP              = 10,
  parameter int V_SYNC            = 2,
  parameter int V_BP              = 33,
  parameter int SCALE_SHIFT       = 1,
  parameter int PIX_DIV           = 4,
  parameter int PIPE_LATENCY      = 4,
  parameter int FB_BITS           = 17,
  parameter int PIXEL_COLOR_WIDTH = 12
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  output logic [FB_BITS-1:0]           pixel_index_o,
  input  logic [PIXEL_COLOR_WIDTH-1:0] pixel_color_i,
`ifdef VGA_SCANNER_TEST_PATTERN_EN
  input  logic                         test_pattern_i,
`endif
  output logic [3:0]                   vga_r_o,
  output logic [3:0]                   vga_g_o,
  output logic [3:0]                   vga_b_o,
  output logic                         vga_hs_o,
  output logic                         vga_vs_o,
  output logic                         frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int DIV_W   = $clog2(PIX_DIV);
  localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  // Low SCALE_SHIFT bits of vcount all set marks the last repeat of a framebuffer row.
  localparam logic [VC_W-1:0] ROW_LAST_MASK = VC_W'((1 << SCALE_SHIFT) - 1);

  logic [DIV_W-1:0]   div;
  logic               tick;
  logic [HC_W-1:0]    hcount;
  logic [HC_W-1:0]    hcount_nxt;
  logic [VC_W-1:0]    vcount;
  logic [VC_W-1:0]    vcount_nxt;
  logic [FB_BITS-1:0] row_base;
  logic [FB_BITS-1:0] row_base_nxt;
  logic               h_wrap;
  logic               v_wrap;
  logic               act;
  logic               act_nxt;
  logic               hs;
  logic               vs;

  logic               vld_p1 [PIPE_LATENCY];
  logic               hs_p1  [PIPE_LATENCY];
  logic               vs_p1  [PIPE_LATENCY];
  logic [11:0]        color_sel;

`ifdef VGA_SCANNER_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]         bar;
  logic [2:0]         bar_p1 [PIPE_LATENCY];

  // Bar order white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [11:0] bar_color(input logic [2:0] b);
    return {{4{~b[1]}}, {4{~b[2]}}, {4{~b[0]}}};
  endfunction
`endif

  // Stage p0: pixel-rate divider, raster counters, row base and pixel index
  always_comb begin
    tick         = (div == DIV_W'(PIX_DIV - 1));
    h_wrap       = (hcount == HC_W'(H_TOTAL - 1));
    v_wrap       = (vcount == VC_W'(V_TOTAL - 1));
    hcount_nxt   = h_wrap ? '0 : hcount + 1'b1;
    vcount_nxt   = vcount;
    if (h_wrap) begin
      vcount_nxt = v_wrap ? '0 : vcount + 1'b1;
    end
    row_base_nxt = row_base;
    if (h_wrap && v_wrap) begin
      row_base_nxt = '0;
    end else if (h_wrap && (vcount < VC_W'(V_ACTIVE)) &&
                 ((vcount & ROW_LAST_MASK) == ROW_LAST_MASK)) begin
      row_base_nxt = row_base + FB_BITS'(FB_W);
    end
    act_nxt = (hcount_nxt < HC_W'(H_ACTIVE)) && (vcount_nxt < VC_W'(V_ACTIVE));
    act     = (hcount < HC_W'(H_ACTIVE)) && (vcount < VC_W'(V_ACTIVE));
    hs      = !((hcount >= HC_W'(HS_BEG)) && (hcount < HC_W'(HS_END)));
    vs      = !((vcount >= VC_W'(VS_BEG)) && (vcount < VC_W'(VS_END)));
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      div           <= '0;
      hcount        <= '0;
      vcount        <= '0;
      row_base      <= '0;
      pixel_index_o <= '0;
      frame_start_o <= 1'b0;
    end else begin
      frame_start_o <= tick && h_wrap && v_wrap;
      div           <= tick ? '0 : div + 1'b1;
      if (tick) begin
        hcount   <= hcount_nxt;
        vcount   <= vcount_nxt;
        row_base <= row_base_nxt;
        if (act_nxt) begin
          pixel_index_o <= row_base_nxt + FB_BITS'(hcount_nxt >> SCALE_SHIFT);
        end
      end
    end
  end

  // Stage p1: per-cycle delay line matching the palette lookup latency
`ifdef VGA_SCANNER_TEST_PATTERN_EN
  assign bar = 3'(hcount / HC_W'(BAR_W));
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        vld_p1[i] <= 1'b0;
        hs_p1[i]  <= 1'b1;
        vs_p1[i]  <= 1'b1;
`ifdef VGA_SCANNER_TEST_PATTERN_EN
        bar_p1[i] <= '0;
`endif
      end
    end else begin
      vld_p1[0] <= act;
      hs_p1[0]  <= hs;
      vs_p1[0]  <= vs;
`ifdef VGA_SCANNER_TEST_PATTERN_EN
      bar_p1[0] <= bar;
`endif
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        vld_p1[i] <= vld_p1[i-1];
        hs_p1[i]  <= hs_p1[i-1];
        vs_p1[i]  <= vs_p1[i-1];
`ifdef VGA_SCANNER_TEST_PATTERN_EN
        bar_p1[i] <= bar_p1[i-1];
`endif
      end
    end
  end

  // Stage p2: registered pins, colour blanked outside the active window
  always_comb begin
    color_sel = pixel_color_i[11:0];
`ifdef VGA_SCANNER_TEST_PATTERN_EN
    if (test_pattern_i) begin
      color_sel = bar_color(bar_p1[PIPE_LATENCY-1]);
    end
`endif
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      vga_r_o  <= '0;
      vga_g_o  <= '0;
      vga_b_o  <= '0;
      vga_hs_o <= 1'b1;
      vga_vs_o <= 1'b1;
    end else begin
      if (vld_p1[PIPE_LATENCY-1]) begin
        vga_r_o <= color_sel[11:8];
        vga_g_o <= color_sel[7:4];
        vga_b_o <= color_sel[3:0];
      end else begin
        vga_r_o <= '0;
        vga_g_o <= '0;
        vga_b_o <= '0;
      end
      vga_hs_o <= hs_p1[PIPE_LATENCY-1];
      vga_vs_o <= vs_p1[PIPE_LATENCY-1];
    end
  end

endmodule
